// File: rtl/sekiz_cikis_demux_pkg.sv
// Shared constants and types for the 1-to-8 registered word demultiplexer.
package sekiz_cikis_demux_pkg;

    localparam int WIDTH = 32;
    localparam int N_OUT = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 16;

    typedef logic [SEL_W-1:0] slot_idx_t;

endpackage : sekiz_cikis_demux_pkg

// File: rtl/sekiz_cikis_demux_if.sv
// Source/consumer bus of the demultiplexer. The slave modport is the demux view.
interface sekiz_cikis_demux_if;
    import sekiz_cikis_demux_pkg::*;

    logic [WIDTH-1:0]       in_data;
    logic                   en1;
    logic                   en2;
    logic                   en3;
    logic                   auto_mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    slot_idx_t              rr_ptr;
    logic [CNT_W-1:0]       xfer_count;

    modport slave (
        input  in_data, en1, en2, en3, auto_mode, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, xfer_count
    );

    modport master (
        output in_data, en1, en2, en3, auto_mode, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, xfer_count
    );

endinterface : sekiz_cikis_demux_if

// File: rtl/sekiz_cikis_demux_yuva.sv
// One-entry holding register for a single output slot.
// A load always wins over a drain so a same-cycle drain+load keeps the slot full.
module otuziki_cikis_yuvasi
    import sekiz_cikis_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Capture a new word on load; clear valid on drain, data keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : otuziki_cikis_yuvasi

// File: rtl/sekiz_cikis_demux.sv
// Registered 1-to-8 demultiplexer: steers a word to a slot chosen by
// {en3,en2,en1} or by a round-robin pointer, with per-slot back-pressure.
// in_ready combinationally depends on out_ready of the targeted slot.
module sekiz_cikis_demux
    import sekiz_cikis_demux_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    sekiz_cikis_demux_if.slave  bus
);

    slot_idx_t              r_rr_ptr;
    logic [CNT_W-1:0]       r_xfer_count;
    slot_idx_t              w_tgt;
    logic                   w_in_ready;
    logic                   w_accept;
    logic [N_OUT-1:0]       w_valid;
    logic [WIDTH-1:0]       w_slot_data [N_OUT];
    logic [N_OUT*WIDTH-1:0] w_out_data;

    assign w_tgt      = bus.auto_mode ? r_rr_ptr : {bus.en3, bus.en2, bus.en1};
    assign w_in_ready = ~w_valid[w_tgt] | bus.out_ready[w_tgt];
    assign w_accept   = bus.in_valid & w_in_ready;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        otuziki_cikis_yuvasi u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_accept && (w_tgt == slot_idx_t'(k))),
            .i_data  (bus.in_data),
            .i_ready (bus.out_ready[k]),
            .o_valid (w_valid[k]),
            .o_data  (w_slot_data[k])
        );
    end

    // Flatten the slot registers onto the output bus, slot k at [k*WIDTH +: WIDTH].
    always_comb begin
        w_out_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_out_data[k*WIDTH +: WIDTH] = w_slot_data[k];
        end
    end

    // Count accepted words and advance the pointer only on auto-mode accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_xfer_count <= '0;
        end else if (w_accept) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
            if (bus.auto_mode) begin
                r_rr_ptr <= r_rr_ptr + slot_idx_t'(1);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_data   = w_out_data;
    assign bus.out_valid  = w_valid;
    assign bus.rr_ptr     = r_rr_ptr;
    assign bus.xfer_count = r_xfer_count;

endmodule : sekiz_cikis_demux

// File: tb/tb_sekiz_cikis_demux.sv
// Directed bench for sekiz_cikis_demux.
module tb_sekiz_cikis_demux;
    import sekiz_cikis_demux_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   stalls;

    sekiz_cikis_demux_if bus ();

    sekiz_cikis_demux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int k);
        return bus.out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic set_sel(input logic [2:0] s);
        {bus.en3, bus.en2, bus.en1} = s;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        stalls = 0;
        rst_n = 1'b0;
        bus.in_data   = '0;
        bus.en1       = 1'b0;
        bus.en2       = 1'b0;
        bus.en3       = 1'b0;
        bus.auto_mode = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", {24'd0, bus.out_valid}, 32'h0);
        chk("rst_rr", {29'd0, bus.rr_ptr}, 32'd0);
        chk("rst_cnt", {16'd0, bus.xfer_count}, 32'd0);
        chk("rst_data5", slot(5), 32'h0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1. Manual load to slot 5
        set_sel(3'b101);
        bus.in_data  = 32'hDEADBEEF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_valid", {24'd0, bus.out_valid}, 32'h20);
        chk("t1_data5", slot(5), 32'hDEADBEEF);
        chk("t1_cnt", {16'd0, bus.xfer_count}, 32'd1);

        // 2. Back-pressure then simultaneous drain+load
        bus.in_data  = 32'h12345678;
        bus.in_valid = 1'b1;
        #1;
        chk("t2_stall_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("t2_hold_data5", slot(5), 32'hDEADBEEF);
        chk("t2_hold_cnt", {16'd0, bus.xfer_count}, 32'd1);
        bus.out_ready = 8'h20;
        #1;
        chk("t2_ready_comb", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        chk("t2_data5", slot(5), 32'h12345678);
        chk("t2_valid", {24'd0, bus.out_valid}, 32'h20);
        chk("t2_cnt", {16'd0, bus.xfer_count}, 32'd2);
        bus.out_ready = 8'h20;
        tick();
        bus.out_ready = 8'h00;
        chk("t2_drained", {24'd0, bus.out_valid}, 32'h0);
        chk("t2_rr_manual", {29'd0, bus.rr_ptr}, 32'd0);

        // 3. Auto-mode sweep, 9 words, all consumers ready
        bus.auto_mode = 1'b1;
        set_sel(3'b111);
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in_data = i;
            tick();
            chk($sformatf("t3_data_w%0d", i), slot(i % 8), i);
            chk($sformatf("t3_valid_w%0d", i), {24'd0, bus.out_valid}, 32'd1 << (i % 8));
        end
        bus.in_valid = 1'b0;
        chk("t3_rr_end", {29'd0, bus.rr_ptr}, 32'd1);
        chk("t3_cnt", {16'd0, bus.xfer_count}, 32'd11);
        chk("t3_slot1_hold", slot(1), 32'd1);
        chk("t3_slot7", slot(7), 32'd7);
        tick();
        bus.out_ready = 8'h00;
        bus.auto_mode = 1'b0;
        chk("t3_all_drained", {24'd0, bus.out_valid}, 32'h0);

        // 4. Independent drain of slot 0 while slot 7 stays full
        set_sel(3'b000);
        bus.in_data  = 32'hA0A0A0A0;
        bus.in_valid = 1'b1;
        tick();
        set_sel(3'b111);
        bus.in_data = 32'h7B7B7B7B;
        tick();
        bus.in_valid = 1'b0;
        chk("t4_filled", {24'd0, bus.out_valid}, 32'h81);
        bus.out_ready = 8'h01;
        tick();
        bus.out_ready = 8'h00;
        chk("t4_drain0", {24'd0, bus.out_valid}, 32'h80);
        chk("t4_data0_hold", slot(0), 32'hA0A0A0A0);
        chk("t4_data7", slot(7), 32'h7B7B7B7B);
        chk("t4_rr", {29'd0, bus.rr_ptr}, 32'd1);
        bus.out_ready = 8'h80;
        tick();
        bus.out_ready = 8'h00;

        // 5. Asynchronous reset mid-operation (slots 1..3 full, rr_ptr 4)
        bus.auto_mode = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 32'h100 + i;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t5_pre_valid", {24'd0, bus.out_valid}, 32'h0E);
        chk("t5_pre_rr", {29'd0, bus.rr_ptr}, 32'd4);
        chk("t5_pre_cnt", {16'd0, bus.xfer_count}, 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", {24'd0, bus.out_valid}, 32'h0);
        chk("t5_rr", {29'd0, bus.rr_ptr}, 32'd0);
        chk("t5_cnt", {16'd0, bus.xfer_count}, 32'd0);
        chk("t5_data2", slot(2), 32'h0);
        bus.auto_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 6. Counter wrap: 65536 back-to-back accepts to slot 0
        set_sel(3'b000);
        bus.out_ready = 8'h01;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.in_data = i;
            #1;
            if (bus.in_ready !== 1'b1) stalls++;
            tick();
            if (i == 65534) chk("t6_cnt_ffff", {16'd0, bus.xfer_count}, 32'h0000FFFF);
        end
        bus.in_valid = 1'b0;
        chk("t6_no_stall", stalls, 32'd0);
        chk("t6_cnt_wrap", {16'd0, bus.xfer_count}, 32'd0);
        chk("t6_data0", slot(0), 32'd65535);
        chk("t6_valid0", {24'd0, bus.out_valid}, 32'h01);
        tick();
        bus.out_ready = 8'h00;
        chk("t6_drained", {24'd0, bus.out_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sekiz_cikis_demux
